// File: rtl/gate_test_pkg.sv
// Shared types and constants for the two-input gate stimulus/checker slice.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned VEC_COUNT = 4;

  // Packed truth table, vector 3..0 = 00,01,01,11 ({NOR,NAND} per vector).
  localparam logic [7:0] EXPECTED = 8'h17;

  function automatic logic [1:0] exp_y(input logic a, input logic b);
    return {~(a | b), ~(a & b)};
  endfunction

endpackage

// File: rtl/ab_pattern_seq_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the final cycle.
module dwell_counter #(
  parameter int DWELL = 50,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  if (DWELL < 2 || DWELL > (1 << CNT_W)) begin : g_bad_dwell
    $error("dwell_counter: DWELL out of range 2..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == LAST_CNT);

  // Wrap-to-zero happens on the compare, so cnt never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (last) cnt <= '0;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ab_pattern_seq.sv
// Sweeps gate inputs a,b through 00,01,10,11, samples y per vector and
// checks the packed result against the NOR/NAND truth table.
module ab_pattern_seq
  import gate_test_pkg::*;
#(
  parameter int DWELL = 50,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] y_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       pass
);

  localparam logic [1:0] LAST_IDX = 2'(VEC_COUNT - 1);

  state_t     state;
  logic [1:0] idx;
  logic       last;
  logic       clear;
  logic       enable;
  logic [7:0] res_next;

  assign enable = (state == RUN);
  assign clear  = (state != RUN) && start;

  dwell_counter #(
    .DWELL(DWELL),
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .enable(enable),
    .last  (last)
  );

  // Result with the current sample merged in; pass is judged on this value.
  always_comb begin
    res_next = result;
    res_next[{idx, 1'b0} +: 2] = y_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a      <= 1'b0;
      b      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      pass   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= RUN;
            idx    <= '0;
            a      <= 1'b0;
            b      <= 1'b0;
            busy   <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            pass   <= 1'b0;
          end
        end
        RUN: begin
          if (last) begin
            result <= res_next;
            if (idx != LAST_IDX) begin
              idx    <= idx + 2'd1;
              {a, b} <= idx + 2'd1;
            end else begin
              state  <= DONE;
              idx    <= '0;
              {a, b} <= 2'b00;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (res_next == EXPECTED);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ab_pattern_seq.sv
// Self-checking bench: two sequencer instances (DWELL=50 and DWELL=2) driving a
// behavioural NOR/NAND gate with optional per-vector output overrides.
module tb_ab_pattern_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  always #5 clk = ~clk;

  logic       a0, b0, busy0, done0, pass0;
  logic [7:0] res0;
  logic [1:0] y0;
  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] res1;
  logic [1:0] y1;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  logic [1:0] gate_tt [4] = '{2'b11, 2'b01, 2'b01, 2'b00};
  logic [1:0] ovr_val [4];
  logic       ovr_en  [4];

  assign y0 = ovr_en[{a0, b0}] ? ovr_val[{a0, b0}] : {~(a0 | b0), ~(a0 & b0)};
  assign y1 = ovr_en[{a1, b1}] ? ovr_val[{a1, b1}] : {~(a1 | b1), ~(a1 & b1)};

  ab_pattern_seq #(.DWELL(50), .CNT_W(6)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .result(res0), .pass(pass0)
  );

  ab_pattern_seq #(.DWELL(2), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .result(res1), .pass(pass1)
  );

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [7:0] o_res;
  assign o_a    = (cur != 0) ? a1    : a0;
  assign o_b    = (cur != 0) ? b1    : b0;
  assign o_busy = (cur != 0) ? busy1 : busy0;
  assign o_done = (cur != 0) ? done1 : done0;
  assign o_pass = (cur != 0) ? pass1 : pass0;
  assign o_res  = (cur != 0) ? res1  : res0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s (dut%0d): observed %0h expected %0h", tag, cur, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (cur != 0) start1 = v;
    else          start0 = v;
  endtask

  task automatic clear_ovr();
    for (int i = 0; i < 4; i++) begin
      ovr_en[i]  = 1'b0;
      ovr_val[i] = 2'b00;
    end
  endtask

  task automatic rand_ovr();
    for (int i = 0; i < 4; i++) begin
      ovr_en[i]  = ($urandom_range(0, 2) == 0);
      ovr_val[i] = 2'($urandom_range(0, 3));
    end
  endtask

  // Expected packed word: what the gate (or override) presents for each vector.
  task automatic model_result(output logic [7:0] r);
    for (int i = 0; i < 4; i++)
      r[2*i +: 2] = ovr_en[i] ? ovr_val[i] : gate_tt[i];
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ab"},     {o_a, o_b}, 0);
    check({tag, "_busy"},   o_busy, 0);
    check({tag, "_done"},   o_done, 0);
    check({tag, "_result"}, o_res, 0);
    check({tag, "_pass"},   o_pass, 0);
  endtask

  task automatic sweep(input bit spam);
    int dw;
    int k;
    logic [7:0] exp_r;
    dw = (cur != 0) ? 2 : 50;
    model_result(exp_r);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    check("start_busy",   o_busy, 1);
    check("start_done",   o_done, 0);
    check("start_result", o_res, 0);
    check("start_ab",     {o_a, o_b}, 0);
    check("start_pass",   o_pass, 0);
    k = 0;
    while (o_busy === 1'b1 && k < 4*dw + 10) begin
      if (k < 4*dw) check("vec_ab", {o_a, o_b}, k / dw);
      check("run_done", o_done, 0);
      check("run_pass", o_pass, 0);
      k++;
      if (spam) set_start(1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    set_start(1'b0);
    check("busy_cycles", k, 4*dw);
    check("end_done",    o_done, 1);
    check("end_result",  o_res, exp_r);
    check("end_pass",    o_pass, (exp_r == 8'h17));
    check("end_ab",      {o_a, o_b}, 0);
    @(negedge clk);
    check("hold_done",   o_done, 1);
    check("hold_result", o_res, exp_r);
    check("hold_busy",   o_busy, 0);
  endtask

  initial begin
    clear_ovr();
    #3;
    cur = 0; #1 check_reset_values("rst0");
    cur = 1; #1 check_reset_values("rst1");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean sweep, then an immediate restart from DONE.
    cur = 0;
    sweep(1'b0);
    sweep(1'b0);

    // NAND output stuck low during vector 1.
    ovr_en[1]  = 1'b1;
    ovr_val[1] = 2'b00;
    sweep(1'b0);
    clear_ovr();

    // start hammered while running must not restart the sweep.
    sweep(1'b1);

    // Asynchronous reset mid-sweep.
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (120) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("postrst");
    sweep(1'b0);

    // Minimal dwell instance.
    cur = 1;
    sweep(1'b0);
    for (int n = 0; n < 6; n++) begin
      rand_ovr();
      sweep(1'($urandom_range(0, 1)));
    end
    clear_ovr();
    sweep(1'b1);

    cur = 0;
    for (int n = 0; n < 2; n++) begin
      rand_ovr();
      sweep(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
